// File: rtl/hs_pkg.sv
// hs_pkg: shared encodings and default widths for the handshake responder
package hs_pkg;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK = 1'b1;
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE = 2'd1;
    localparam logic [1:0] CNT_FULL = 2'd2;
    localparam int DEF_W = 8;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/hs_fifo2.sv
// hs_fifo2: two-entry register buffer with head at buf0
module hs_fifo2
    import hs_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);
    logic [W-1:0] buf0, buf1;
    logic [1:0] count;
    assign head = buf0;
    assign valid = count != CNT_EMPTY;
    assign full = count == CNT_FULL;
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_EMPTY;
            buf0 <= '0;
            buf1 <= '0;
        end else if (push && pop) begin
            buf0 <= push_data;
        end else if (push) begin
            if (count == CNT_EMPTY) buf0 <= push_data;
            else buf1 <= push_data;
            count <= count + 2'd1;
        end else if (pop) begin
            buf0 <= buf1;
            count <= count - 2'd1;
        end
    end
endmodule

// File: rtl/hs_responder.sv
// hs_responder: 4-phase req/ack responder feeding a valid/ready buffer
module hs_responder
    import hs_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [W-1:0]     data,
    output logic             ack,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic [0:0] state, state_nxt;
    logic full, capture;
    assign capture = (state == S_IDLE) && req && !full;
    assign ack = state == S_ACK;
    always_comb state_nxt = (state == S_IDLE) ? (capture ? S_ACK : S_IDLE) : (req ? S_ACK : S_IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            xfer_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
    hs_fifo2 #(.W(W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(capture),
        .push_data(data),
        .pop(out_valid && out_ready),
        .head(out_data),
        .valid(out_valid),
        .full(full)
    );
endmodule
